// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and flush bubbles.
// stall is combinational from the EX registers and the ID inputs; every ex_* output is registered.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [6:0]       id_opcode,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [2:0]       id_funct3,
  input  logic             id_funct7_5,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic             id_mem_rd,
  input  logic             id_mem_wr,
  input  logic             id_reg_wr,
  input  logic             id_mux_reg_wr,
  input  logic             id_mux_ula,
  input  logic             id_branch,
  input  logic [1:0]       id_ula_op,
  output logic             stall,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [2:0]       ex_funct3,
  output logic             ex_funct7_5,
  output logic             ex_mem_rd,
  output logic             ex_mem_wr,
  output logic             ex_reg_wr,
  output logic             ex_mux_reg_wr,
  output logic             ex_mux_ula,
  output logic             ex_branch,
  output logic [1:0]       ex_ula_op,
  output logic [CNT_W-1:0] bubble_count
);
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc, rs1_data, rs2_data, imm;
    logic [4:0]      rs1, rs2, rd;
    logic [2:0]      funct3;
    logic            funct7_5;
    logic            mem_rd, mem_wr, reg_wr, mux_reg_wr, mux_ula;
    logic [1:0]      ula_op;
    logic            branch;
  } ex_t;

  ex_t              ex_q, ex_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             uses_rs1, uses_rs2, load_ex, hazard, bubble;

  // LUI, AUIPC and JAL carry no rs1; only R-type, stores and branches read rs2.
  assign uses_rs1 = !(id_opcode inside {7'b0110111, 7'b0010111, 7'b1101111});
  assign uses_rs2 = id_opcode inside {7'b0110011, 7'b0100011, 7'b1100011};
  // Stores also raise mem_rd, so mem_wr must be low for a real load.
  assign load_ex  = ex_q.valid & ex_q.mem_rd & ~ex_q.mem_wr;
  assign hazard   = id_valid & load_ex & (ex_q.rd != 5'd0) &
                    ((uses_rs1 & (id_rs1 == ex_q.rd)) | (uses_rs2 & (id_rs2 == ex_q.rd)));
  assign stall    = hazard & ~flush;
  assign bubble   = flush | hazard;

  always_comb begin
    ex_d  = '0;
    cnt_d = cnt_q;
    if (bubble) begin
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end else begin
      ex_d.valid    = id_valid;
      ex_d.pc       = id_pc;
      ex_d.rs1_data = id_rs1_data;
      ex_d.rs2_data = id_rs2_data;
      ex_d.imm      = id_imm;
      ex_d.rs1      = id_rs1;
      ex_d.rs2      = id_rs2;
      ex_d.rd       = id_rd;
      ex_d.funct3   = id_funct3;
      ex_d.funct7_5 = id_funct7_5;
      if (id_valid) begin
        ex_d.mem_rd     = id_mem_rd;
        ex_d.mem_wr     = id_mem_wr;
        ex_d.reg_wr     = id_reg_wr;
        ex_d.mux_reg_wr = id_mux_reg_wr;
        ex_d.mux_ula    = id_mux_ula;
        ex_d.ula_op     = id_ula_op;
        ex_d.branch     = id_branch;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign ex_valid      = ex_q.valid;
  assign ex_pc         = ex_q.pc;
  assign ex_rs1_data   = ex_q.rs1_data;
  assign ex_rs2_data   = ex_q.rs2_data;
  assign ex_imm        = ex_q.imm;
  assign ex_rs1        = ex_q.rs1;
  assign ex_rs2        = ex_q.rs2;
  assign ex_rd         = ex_q.rd;
  assign ex_funct3     = ex_q.funct3;
  assign ex_funct7_5   = ex_q.funct7_5;
  assign ex_mem_rd     = ex_q.mem_rd;
  assign ex_mem_wr     = ex_q.mem_wr;
  assign ex_reg_wr     = ex_q.reg_wr;
  assign ex_mux_reg_wr = ex_q.mux_reg_wr;
  assign ex_mux_ula    = ex_q.mux_ula;
  assign ex_branch     = ex_q.branch;
  assign ex_ula_op     = ex_q.ula_op;
  assign bubble_count  = cnt_q;
endmodule
